slow_ram: RTL and testbench

- Word-addressed backing memory behind the direct-mapped cache. The cache drives its data, address and write-enable straight through to this block.
- A request is any change of {data, addr, wr}. The block completes each request after a fixed multi-cycle latency.
- Completion is signalled by a level `response` that stays high until the request changes.

---
 rtl/slow_ram.sv | 105 ++++++++++
 tb/tb_slow_ram.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/slow_ram.sv
// Word-addressed backing memory that completes each request after a fixed LATENCY.
// Optional macro SLOW_RAM_ERR_EN adds an err output that flags addresses outside DEPTH.
module slow_ram #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [31:0]       addr,
  input  logic              wr,
  output logic              response,
`ifdef SLOW_RAM_ERR_EN
  output logic              err,
`endif
  output logic [DATA_W-1:0] out
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Request/response protocol: a request is any change of {data, addr, wr};
  // response is a level that rises LATENCY edges after capture and stays high
  // until the request changes. A change before completion abandons the old request.

  logic [DATA_W-1:0] lat_data;
  logic [31:0]       lat_addr;
  logic              lat_wr;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic              start;

  // Zero initialiser lets reads of never-written words return 0 in simulation.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              new_req;
  logic              complete;
  logic              mem_we;
  logic [DATA_W-1:0] c_data;
  logic [ADDR_W-1:0] c_idx;
  logic              c_wr;
`ifdef SLOW_RAM_ERR_EN
  logic [31:0]       c_addr;
`endif

  always_comb begin
    new_req  = start || (data != lat_data) || (addr != lat_addr) || (wr != lat_wr);
    complete = 1'b0;
    if (new_req) complete = (LATENCY == 1);
    else         complete = busy && (cnt == '0);
    // With LATENCY=1 the capturing edge also completes, so use the live inputs.
    c_data = new_req ? data : lat_data;
    c_idx  = new_req ? addr[ADDR_W-1:0] : lat_addr[ADDR_W-1:0];
    c_wr   = new_req ? wr : lat_wr;
`ifdef SLOW_RAM_ERR_EN
    c_addr = new_req ? addr : lat_addr;
`endif
    mem_we = !reset && complete && c_wr;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= c_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      response <= 1'b0;
      out      <= '0;
      busy     <= 1'b0;
      cnt      <= '0;
      lat_data <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      start    <= 1'b1;
`ifdef SLOW_RAM_ERR_EN
      err      <= 1'b0;
`endif
    end else begin
      if (new_req) begin
        lat_data <= data;
        lat_addr <= addr;
        lat_wr   <= wr;
        cnt      <= CNT_W'(LATENCY - 1);
        busy     <= 1'b1;
        response <= 1'b0;
        start    <= 1'b0;
`ifdef SLOW_RAM_ERR_EN
        err      <= 1'b0;
`endif
      end else if (busy && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (complete) begin
        out      <= c_wr ? c_data : mem[c_idx];
        response <= 1'b1;
        busy     <= 1'b0;
`ifdef SLOW_RAM_ERR_EN
        err      <= |c_addr[31:ADDR_W];
`endif
      end
    end
  end

endmodule

// File: tb/tb_slow_ram.sv
// Bench for slow_ram: directed test-plan scenarios plus random traffic, every edge
// compared against an age-based reference model.
module tb_slow_ram;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 1024;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 4;
  localparam int EW      = DATA_W + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] data = '0;
  logic [31:0]       addr = '0;
  logic              wr = 1'b0;
  logic              response;
  logic [DATA_W-1:0] out;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  slow_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .addr     (addr),
    .wr       (wr),
    .response (response),
`ifdef SLOW_RAM_ERR_EN
    .err      (err),
`endif
    .out      (out)
  );

`ifndef SLOW_RAM_ERR_EN
  assign err = 1'b0;
`endif

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the current request and how many edges it has aged since capture.
  logic [DATA_W-1:0] m_mem [int];
  logic              m_have = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [31:0]       m_addr;
  logic              m_wr;
  int                m_age = 0;
  logic              m_resp = 1'b0;
  logic [DATA_W-1:0] m_out = '0;
  logic              m_err = 1'b0;

  task automatic model_complete();
    int idx;
    idx = int'(m_addr % DEPTH);
    if (m_wr) begin
      m_mem[idx] = m_data;
      m_out = m_data;
    end else begin
      m_out = m_mem.exists(idx) ? m_mem[idx] : '0;
    end
    m_resp = 1'b1;
    m_err  = (m_addr / DEPTH) != 0;
  endtask

  task automatic model_step();
    if (reset) begin
      m_have = 1'b0;
      m_resp = 1'b0;
      m_out  = '0;
      m_err  = 1'b0;
    end else if (!m_have || data != m_data || addr != m_addr || wr != m_wr) begin
      m_have = 1'b1;
      m_data = data;
      m_addr = addr;
      m_wr   = wr;
      m_age  = 0;
      m_resp = 1'b0;
      m_err  = 1'b0;
      if (LATENCY == 1) model_complete();
    end else if (!m_resp) begin
      m_age++;
      if (m_age == LATENCY) model_complete();
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic          mon_en = 1'b1;

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      model_step();
      exp_q.push_back({m_err, m_resp, m_out});
      @(negedge clk);
      e = exp_q.pop_front();
      if (mon_en) begin
        check("mon_response", 64'(response), 64'(e[DATA_W]));
        check("mon_out", 64'(out), 64'(e[DATA_W-1:0]));
`ifdef SLOW_RAM_ERR_EN
        check("mon_err", 64'(err), 64'(e[DATA_W+1]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic [DATA_W-1:0] d, input logic [31:0] a, input logic w);
    data = d;
    addr = a;
    wr   = w;
  endtask

  // Drive a new request and count edges (capture edge included) until response.
  task automatic run_req(input string tag, input logic [DATA_W-1:0] d,
                         input logic [31:0] a, input logic w);
    int edges;
    set_req(d, a, w);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!response && edges < LATENCY + 8);
    check({tag, "_latency"}, 64'(edges), 64'(LATENCY + 1));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    hold(n);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] held;
    hold(2);
    do_reset(1);
    check("rst_response", 64'(response), 64'(0));
    check("rst_out", 64'(out), 64'(0));

    run_req("first", '0, 32'd0, 1'b0);
    check("first_out", 64'(out), 64'(0));

    run_req("wr5", 32'hDEADBEEF, 32'd5, 1'b1);
    check("wr5_out", 64'(out), 64'hDEADBEEF);
    run_req("rd5", 32'hDEADBEEF, 32'd5, 1'b0);
    check("rd5_out", 64'(out), 64'hDEADBEEF);

    // Retarget a write mid-flight: only the new address is written.
    set_req(32'd1, 32'd7, 1'b1);
    hold(2);
    check("abort_resp", 64'(response), 64'(0));
    run_req("wr8", 32'd1, 32'd8, 1'b1);
    run_req("rd7", 32'd0, 32'd7, 1'b0);
    check("rd7_out", 64'(out), 64'(0));
    run_req("rd8", 32'd0, 32'd8, 1'b0);
    check("rd8_out", 64'(out), 64'(1));

    run_req("wr_alias", 32'h12345678, 32'd1027, 1'b1);
`ifdef SLOW_RAM_ERR_EN
    check("alias_err_wr", 64'(err), 64'(1));
`endif
    run_req("rd3", 32'd0, 32'd3, 1'b0);
    check("rd3_out", 64'(out), 64'h12345678);
`ifdef SLOW_RAM_ERR_EN
    check("alias_err_rd", 64'(err), 64'(0));
`endif

    // Reset two edges into a write discards it.
    set_req(32'd55, 32'd9, 1'b1);
    hold(2);
    do_reset(1);
    check("rst_abort_resp", 64'(response), 64'(0));
    check("rst_abort_out", 64'(out), 64'(0));
    run_req("rd9", 32'd0, 32'd9, 1'b0);
    check("rd9_out", 64'(out), 64'(0));

    held = out;
    run_req("idle_wr", 32'hA5A5_0F0F, 32'd20, 1'b1);
    held = out;
    for (int i = 0; i < 10; i++) begin
      hold(1);
      check("idle_resp", 64'(response), 64'(1));
      check("idle_out", 64'(out), 64'(held));
    end

    // Random traffic over a small address window with occasional aliasing and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        set_req($urandom, ($urandom_range(0, 3) == 0 ? {$urandom_range(0, 3), 10'd0} : 32'd0)
                          | 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        hold($urandom_range(1, LATENCY + 3));
      end
    end

    hold(3);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
